// File: rtl/texture_fetch_arbiter.sv
// Round-robin arbiter sharing one texture ROM among NUM_REQ texel fetchers.
// Optional macro TEXARB_TRANSPARENT_EN adds the resp_transparent output.
module texture_fetch_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ROM_LAT  = 1,
  parameter int TEX_BITS = 2
) (
  input  logic                         vga_clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [4*NUM_REQ-1:0]         u,
  input  logic [4*NUM_REQ-1:0]         v,
  input  logic [TEX_BITS*NUM_REQ-1:0]  tex_id,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [8+TEX_BITS-1:0]        rom_addr,
  input  logic [7:0]                   rom_q,
  output logic [NUM_REQ-1:0]           resp_valid,
  output logic [7:0]                   resp_data,
  output logic                         busy
`ifdef TEXARB_TRANSPARENT_EN
  ,
  output logic                         resp_transparent
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state, state_next;
  logic [PTR_W-1:0]       ptr;
  logic [ROM_LAT-1:0]     pipe_vld;
  logic [NUM_REQ-1:0]     pipe_id [ROM_LAT];
  logic [NUM_REQ-1:0]     cand;
  logic [NUM_REQ-1:0]     win_onehot;
  logic                   win_found;
  logic [PTR_W-1:0]       win_idx;
  logic [8+TEX_BITS-1:0]  win_addr;
  logic                   pipe_busy;

  assign pipe_busy = |pipe_vld;
  assign busy      = (state != IDLE) | pipe_busy;

  // The requester granted this cycle is masked, so a lone requester gets every other slot.
  always_comb begin
    cand       = req & ~gnt;
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    win_addr   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_found && cand[(int'(ptr) + k) % NUM_REQ]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
    if (state != RUN) begin
      win_found = 1'b0;
    end
    if (win_found) begin
      win_onehot = NUM_REQ'(1) << win_idx;
      win_addr   = {tex_id[TEX_BITS*int'(win_idx) +: TEX_BITS],
                    v[4*int'(win_idx) +: 4],
                    u[4*int'(win_idx) +: 4]};
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (!enable) state_next = DRAIN;
      DRAIN: begin
        if (enable)          state_next = RUN;
        else if (!pipe_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= PTR_W'(NUM_REQ - 1);
      gnt        <= '0;
      rom_addr   <= '0;
      pipe_vld   <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        pipe_id[i] <= '0;
      end
      resp_valid <= '0;
      resp_data  <= '0;
    end else begin
      state <= state_next;
      gnt   <= win_onehot;
      if (win_found) begin
        ptr      <= win_idx;
        rom_addr <= win_addr;
      end
      // Last stage lines up with rom_q being valid for that grant's address.
      pipe_vld[0] <= win_found;
      pipe_id[0]  <= win_onehot;
      for (int i = 1; i < ROM_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_id[i]  <= pipe_id[i-1];
      end
      resp_valid <= pipe_vld[ROM_LAT-1] ? pipe_id[ROM_LAT-1] : '0;
      if (pipe_vld[ROM_LAT-1]) begin
        resp_data <= rom_q;
      end
    end
  end

`ifdef TEXARB_TRANSPARENT_EN
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      resp_transparent <= 1'b0;
    end else begin
      resp_transparent <= pipe_vld[ROM_LAT-1] && (rom_q == 8'h00);
    end
  end
`endif

endmodule

// File: doc/texture_fetch_arbiter.md
Name: texture_fetch_arbiter

Overview:
Shares one texture ROM among NUM_REQ pixel or column requesters, e.g. parallel raycaster texel fetch units. Each requester presents texture id and texel coordinates (u,v). The block grants round-robin, forms the ROM address, tracks in-flight reads through the ROM latency, and returns the palette index to the granted requester with a valid pulse. Palette lookup stays downstream in each requester.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ROM_LAT, 1, ROM read latency in vga_clk cycles, from rom_addr to rom_q (1..3)
TEX_BITS, 2, texture-id width; ROM holds 2**TEX_BITS textures of 16x16 texels

Ports:
vga_clk  in  1  system clock; all state updates on posedge
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = arbitration allowed; 0 = finish in-flight reads, then idle
req  in  NUM_REQ  per-requester request; held high with operands until gnt
u  in  4*NUM_REQ  texel column per requester, slice i = [4i+3:4i]
v  in  4*NUM_REQ  texel row per requester
tex_id  in  TEX_BITS*NUM_REQ  texture select per requester
gnt  out  NUM_REQ  one-hot grant, registered, 1-cycle pulse
rom_addr  out  8+TEX_BITS  registered ROM address
rom_q  in  8  ROM data (palette index)
resp_valid  out  NUM_REQ  one-hot, 1-cycle pulse, marks returned data
resp_data  out  8  palette index for the requester flagged in resp_valid
busy  out  1  high while any read is in flight or FSM not IDLE

Behaviour:
- Reset (async, immediate): gnt=0, resp_valid=0, resp_data=0, rom_addr=0, busy=0, FSM=IDLE, RR pointer=NUM_REQ-1 (so requester 0 has first priority), in-flight pipeline cleared. Reads in flight at reset are discarded and never return.
- FSM states:
  - IDLE: no grants. Go to RUN when enable=1.
  - RUN: arbitrate every cycle. Go to DRAIN when enable=0.
  - DRAIN: no new grants. Go to IDLE once the in-flight pipeline is empty. Go back to RUN if enable=1 again (no need to wait for empty).
- Arbitration, at each posedge in RUN: candidates = req & ~gnt. A requester granted in the current cycle is masked for that edge, so one requester alone gets a grant every 2nd cycle.
  - Winner = first candidate searching from RR pointer+1 upward, with wrap.
  - On a win: gnt[w]=1 for one cycle, pointer=w, rom_addr={tex_id_w, v_w, u_w}, i.e. tex_id*256 + v*16 + u. All of these register on the same edge.
  - No candidates: gnt=0, rom_addr holds its value, pointer unchanged.
- Timing: gnt high in cycle t, rom_addr valid in cycle t, rom_q sampled at the end of cycle t+ROM_LAT-1. resp_valid[w] and resp_data are high in cycle t+ROM_LAT. Total latency from grant = ROM_LAT cycles.
- In-flight tracking: shift register of depth ROM_LAT carrying {valid, one-hot id}. This sustains 1 grant per cycle across different requesters with no bubbles.
- Requester contract: drop req or change operands only after seeing gnt. Dropping req before grant is a legal withdrawal with no grant and no response.
- Exactly one resp_valid bit at most per cycle. Responses return in grant order.
- enable falling in the same cycle as a grant: that grant completes normally and its response is still delivered during DRAIN.
- busy = (FSM!=IDLE) | any in-flight valid.

Optional Feature:
Macro TEXARB_TRANSPARENT_EN.
- Defined: adds output resp_transparent (1 bit), registered with resp_valid. It is 1 when the returned palette index == 8'h00 (transparent texel) and 0 otherwise, and is forced 0 when no resp_valid bit is set. Reset value 0.
- Undefined: the port and its logic are absent. resp_data still carries index 0 unchanged.

Test Plan:
1. Reset released, enable=1, req=4'b0001, u=5, v=3, tex_id=2 -> gnt=0001 one cycle later, rom_addr=0x235. resp_valid=0001 after ROM_LAT more cycles, with resp_data = ROM content at 0x235.
2. req=4'b1111 held continuously, ROM_LAT=1 -> grants 0,1,2,3,0,1,... one per cycle with no idle cycles. Each resp_valid follows its gnt by 1 cycle with the matching data.
3. Single requester holding req=1 for 8 cycles -> gnt toggles 1,0,1,0 (4 grants). Confirms the post-grant mask.
4. ROM_LAT=3, 3 grants issued, then enable=0 -> no further gnt, 3 responses delivered in order, FSM passes DRAIN->IDLE, busy falls the cycle after the last resp_valid.
5. Assert reset while 2 reads are in flight -> all outputs 0 immediately, no resp_valid after release, and the first grant after release goes to requester 0.
6. TEXARB_TRANSPARENT_EN defined, ROM word 0x00 at the requested address -> resp_transparent=1 with resp_valid. Word 0x07 -> resp_transparent=0.
